reg_op_sequencer: RTL
=====================

Name: reg_op_sequencer

Overview:
- Controller for the three-entry general-purpose register block (A, B, out) of the 8-bit crypto processor.
- Accepts one operation request (two operands plus opcode) over a valid/ready handshake.
- Sequences register writes: A, then B; waits a fixed ALU latency; writes the ALU result into the out register; then pulses done.
- Sits between the instruction/host front end and the register block's we_reg / reg_select / data_in write port.

Parameters:
- DATA_W, 8: operand, result and register data width.
- OP_W, 2: opcode width passed through to the ALU.
- ALU_LAT, 2: cycles from the B write to alu_result being valid; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_a  input  DATA_W  operand destined for register A.
- req_b  input  DATA_W  operand destined for register B.
- req_op  input  OP_W  ALU opcode.
- alu_op  output  OP_W  opcode held to the ALU for the whole operation.
- alu_result  input  DATA_W  ALU output, sampled in WR_OUT.
- we_reg  output  1  register write enable.
- reg_select  output  2  register select: 00 = A, 01 = B, 10 = out; 11 never driven.
- reg_data  output  DATA_W  register write data.
- done  output  1  one-cycle pulse: out register written.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, take effect immediately on rst):
  - State = IDLE.
  - we_reg = 0, reg_select = 00, reg_data = 0, alu_op = 0, done = 0, busy = 0.
  - req_ready = 1 once rst is deasserted.
  - Internal a_q, b_q, op_q and cnt = 0.
- Outputs are Moore-decoded from the state register plus the captured operands; no combinational path from req_* to any register-write output.
- Handshake:
  - Transfer occurs on a rising edge where req_valid && req_ready.
  - req_a, req_b and req_op are captured into a_q, b_q and op_q at that edge; later changes on the req_* inputs are ignored.
  - req_valid while req_ready = 0 is ignored; the requester must hold it.
- FSM states and transitions:
  - IDLE: req_ready = 1. On transfer -> WR_A.
  - WR_A: we_reg = 1, reg_select = 00, reg_data = a_q. -> WR_B.
  - WR_B: we_reg = 1, reg_select = 01, reg_data = b_q; cnt <= ALU_LAT. -> WAIT if ALU_LAT > 0, else -> WR_OUT.
  - WAIT: we_reg = 0; cnt decrements each cycle. -> WR_OUT on the cycle cnt == 1, giving exactly ALU_LAT cycles in WAIT.
  - WR_OUT: we_reg = 1, reg_select = 10, reg_data = alu_result (pass-through of the value sampled this cycle). -> DONE.
  - DONE: done = 1 for one cycle, we_reg = 0. -> IDLE.
- alu_op = op_q from WR_A through DONE; it keeps its last value in IDLE.
- Latency, with the transfer at edge k:
  - A write occurs in cycle k+1 and B write in cycle k+2.
  - out write occurs in cycle k+3+ALU_LAT and done in cycle k+4+ALU_LAT.
  - req_ready returns in cycle k+5+ALU_LAT.
  - Throughput is one operation per ALU_LAT+5 cycles.
- Every write cycle has exactly one reg_select value; reg_select = 11 is never produced.
- reg_select and reg_data hold their last values when we_reg = 0.
- Reset mid-operation: the sequence is aborted, we_reg drops asynchronously, no done is produced, and the in-flight request is lost.

Optional Feature:
- Macro: REG_SEQ_PIPE_EN.
- Defined:
  - req_ready is also 1 in DONE.
  - A transfer in DONE captures the new operands and goes directly to WR_A; done is still 1 that cycle.
  - Back-to-back throughput becomes ALU_LAT+4 cycles.
- Undefined: req_ready = 1 only in IDLE, as specified above.

Test Plan:
- Single op, ALU_LAT = 2: req a = 0x3C, b = 0xA5, op = 01, ALU model returns a^b -> writes (00, 0x3C), (01, 0xA5), 2 idle cycles, (10, 0x99); done pulses once; 7 cycles from transfer to req_ready.
- Operand change after handshake: change req_a to 0xFF one cycle after transfer -> A is still written with 0x3C.
- req_valid held high while busy -> no second capture until req_ready; the second request completes with its own values; alu_op tracks each opcode.
- ALU_LAT = 0 build: a = 0x01, b = 0x02 -> WR_B goes straight to WR_OUT; out write occurs 3 cycles after transfer.
- rst asserted during WAIT -> we_reg, busy and done are 0 immediately; no out write; the next request runs normally.
- REG_SEQ_PIPE_EN: two requests presented back-to-back -> the second A write occurs in the cycle after done; total gap is 6 cycles at ALU_LAT = 2.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: sequences A, B and out writes into the GP register block around one ALU operation
// Ports:
//     clk, rst                         clock; asynchronous active-high reset
//     req_valid, req_ready             request handshake
//     req_a, req_b, req_op             operands and opcode, captured on transfer
//     alu_op, alu_result               opcode held to the ALU; ALU result sampled in WR_OUT
//     we_reg, reg_select, reg_data     register block write port (00 = A, 01 = B, 10 = out)
//     done, busy                       one-cycle completion pulse; high outside IDLE
// Optional: define REG_SEQ_PIPE_EN to also accept the next request in DONE.
module reg_op_sequencer #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 2,
    parameter int ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [OP_W-1:0]   req_op,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              we_reg,
    output logic [1:0]        reg_select,
    output logic [DATA_W-1:0] reg_data,
    output logic              done,
    output logic              busy
);
    typedef enum logic [2:0] {S_IDLE, S_WR_A, S_WR_B, S_WAIT, S_WR_OUT, S_DONE} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] a_q, b_q, dat_q;
    logic [OP_W-1:0]   op_q;
    logic [1:0]        sel_q;
    logic [3:0]        cnt;
    logic              xfer;

    assign xfer = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = xfer ? S_WR_A : S_IDLE;
            S_WR_A:   state_n = S_WR_B;
            S_WR_B:   state_n = (ALU_LAT > 0) ? S_WAIT : S_WR_OUT;
            S_WAIT:   state_n = (cnt == 4'd1) ? S_WR_OUT : S_WAIT;
            S_WR_OUT: state_n = S_DONE;
`ifdef REG_SEQ_PIPE_EN
            S_DONE:   state_n = xfer ? S_WR_A : S_IDLE;
`else
            S_DONE:   state_n = S_IDLE;
`endif
            default:  state_n = S_IDLE;
        endcase
    end

    // Outside write cycles the port shows the last written select/data (sel_q/dat_q).
    always_comb begin
        we_reg     = state == S_WR_A || state == S_WR_B || state == S_WR_OUT;
        reg_select = state == S_WR_A ? 2'b00 : state == S_WR_B ? 2'b01 : state == S_WR_OUT ? 2'b10 : sel_q;
        reg_data   = state == S_WR_A ? a_q : state == S_WR_B ? b_q : state == S_WR_OUT ? alu_result : dat_q;
        done       = state == S_DONE;
        busy       = state != S_IDLE;
        alu_op     = op_q;
`ifdef REG_SEQ_PIPE_EN
        req_ready  = !rst && (state == S_IDLE || state == S_DONE);
`else
        req_ready  = !rst && state == S_IDLE;
`endif
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt   <= '0;
            sel_q <= '0;
            dat_q <= '0;
        end else begin
            if (xfer) begin
                a_q  <= req_a;
                b_q  <= req_b;
                op_q <= req_op;
            end
            // Loaded in WR_B so WAIT lasts exactly ALU_LAT cycles, leaving on cnt == 1.
            if (state == S_WR_B) cnt <= 4'(ALU_LAT);
            else if (state == S_WAIT) cnt <= cnt - 4'd1;
            if (we_reg) begin
                sel_q <= reg_select;
                dat_q <= reg_data;
            end
        end
endmodule
